calc_port_sequencer: RTL and testbench
======================================

# calc_port_sequencer

Per-port request sequencer placed directly upstream of one `calc1_top` request port. It accepts a whole calculator transaction (command, operand1, operand2) over a valid/ready handshake and drives the port's two-cycle protocol: the command with operand1, then no-op with operand2. It watches the matching `out_resp`/`out_data` pair and returns the first response, or a timeout, as one result record. Four instances, one per port, sit between the stimulus/transaction source and `calc1_top`.

## Interface
- `TIMEOUT_CYCLES`, default 10: response window in cycles after operand2 is presented; legal range 1..255.
- `c_clk` in 1: clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `txn_valid` in 1: transaction offered.
- `txn_ready` out 1: block can accept; high only in IDLE.
- `txn_cmd` in 4: calculator command.
- `txn_param1` in 32: operand1.
- `txn_param2` in 32: operand2.
- `req_cmd_in` out 4: to `calc1_top` reqN_cmd_in.
- `req_data_in` out 32: to `calc1_top` reqN_data_in.
- `out_resp` in 2: from `calc1_top` out_respN.
- `out_data` in 32: from `calc1_top` out_dataN.
- `rsp_valid` out 1: result available; held until accepted.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_resp` out 2: captured response code; 0 if none.
- `rsp_data` out 32: captured data; 0 if none.
- `rsp_timeout` out 1: nonzero command got no response inside the window.
- `rsp_cycles` out 8: cycles from operand2 presentation to the response; equals TIMEOUT_CYCLES when no response arrives.
- `rsp_stray` out 1: sticky; a nonzero `out_resp` arrived in IDLE, CMD, OP2 or DONE.

## Operation
- FSM states: IDLE, CMD, OP2, WAIT, DONE.
- IDLE: `txn_ready`=1. On `txn_valid`, latch cmd, param1 and param2, then go to CMD.
- CMD: drive `req_cmd_in`=cmd and `req_data_in`=param1 for exactly one cycle, then go to OP2.
- OP2: drive `req_cmd_in`=0 and `req_data_in`=param2 for exactly one cycle. Clear the counter and go to WAIT.
- WAIT: drive cmd=0 and data=0. Each cycle, increment the counter and sample `out_resp`.
  - First cycle with `out_resp`≠0: capture resp and data, set `rsp_cycles`=counter, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no response: resp=0, data=0, `rsp_cycles`=TIMEOUT_CYCLES, `rsp_timeout`=(cmd≠0), go to DONE.
- NOP (cmd 0) uses the same full sequence and full window. A response to a NOP is captured and reported as a normal response; judging it is the checker's job.
- DONE: `rsp_valid`=1 with all result fields stable. On `rsp_ready`, return to IDLE.
- Any nonzero `out_resp` outside WAIT sets `rsp_stray`. It is cleared only by reset.
- Only the first response in WAIT is captured; later responses while still in WAIT cannot occur because the state exits on capture.

## Timing
- Reset values: all outputs 0 except `txn_ready`=1; state IDLE. Reset mid-operation drops the in-flight transaction; ports go to 0 on the next edge.
- Handshake at edge T. `req_*` outputs are registered:
  - cycle T+1 carries cmd/param1.
  - cycle T+2 carries 0/param2.
  - sampling of `out_resp` starts at cycle T+3, which is counter value 1.
- Response seen in cycle T+2+k gives `rsp_cycles`=k, and `rsp_valid` rises the following cycle.
- Throughput is one transaction per (3 + window + 1 + consumer stall) cycles. `txn_ready` is low from T+1 until the cycle after `rsp_ready` is accepted; there is no bypass.
- `rsp_cycles` saturates within 8 bits; the counter width is 8.

## Structure
- Shared package `calc_pkg` holds:
  - `calc_cmd_e`: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - `calc_resp_e`: NONE=0, OK=1, OVF_UNF=2, INVALID=3.
  - the `calc_txn_t` struct holding cmd, param1 and param2.
  - the `calc_rsp_t` struct holding resp, data, timeout and cycles.
- The FSM state enum is local to the module.
- No sub-module; the top level instantiates four copies.

## Test plan
- ADD with 0x5 and 0x1, DUT model replies at k=3 with resp=1, data=0x6: port sees (1,0x5) then (0,0x1); result resp=1, data=0x6, cycles=3, timeout=0.
- NOP with 0x64 and 0x27, no reply: full 10-cycle window, then resp=0, cycles=10, timeout=0.
- ADD with 0xFFFFFFFF and 0x1, DUT replies resp=2: result resp=2, timeout=0; next txn_ready only after rsp_ready.
- SUB with 0x22 and 0x23, no reply, TIMEOUT_CYCLES=4: resp=0, cycles=4, timeout=1.
- Reset asserted in the cycle after CMD: req_cmd_in and req_data_in are 0 next edge, txn_ready=1, rsp_valid never rises.
- Stray out_resp=1 while IDLE: rsp_stray=1 and holds through a later good transaction until reset.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: command/response codes and the transaction and
// result records exchanged by the per-port sequencers.
package calc_pkg;

  localparam int unsigned CmdWidth  = 4;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned CntWidth  = 8;

  typedef enum logic [CmdWidth-1:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdShl = 4'd5,
    CmdShr = 4'd6
  } calc_cmd_e;

  typedef enum logic [1:0] {
    RespNone    = 2'd0,
    RespOk      = 2'd1,
    RespOvfUnf  = 2'd2,
    RespInvalid = 2'd3
  } calc_resp_e;

  typedef struct packed {
    logic [CmdWidth-1:0]  cmd;
    logic [DataWidth-1:0] param1;
    logic [DataWidth-1:0] param2;
  } calc_txn_t;

  typedef struct packed {
    logic [1:0]           resp;
    logic [DataWidth-1:0] data;
    logic                 timeout;
    logic [CntWidth-1:0]  cycles;
  } calc_rsp_t;

endpackage

// File: rtl/calc_port_sequencer_if.sv
// Transaction, calculator-port and result signals of one port sequencer.
interface calc_port_sequencer_if;
  import calc_pkg::*;

  logic                 txn_valid;
  logic                 txn_ready;
  logic [CmdWidth-1:0]  txn_cmd;
  logic [DataWidth-1:0] txn_param1;
  logic [DataWidth-1:0] txn_param2;
  logic [CmdWidth-1:0]  req_cmd_in;
  logic [DataWidth-1:0] req_data_in;
  logic [1:0]           out_resp;
  logic [DataWidth-1:0] out_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_resp;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_timeout;
  logic [CntWidth-1:0]  rsp_cycles;
  logic                 rsp_stray;

  // The sequencer side.
  modport master (
    input  txn_valid, txn_cmd, txn_param1, txn_param2, out_resp, out_data, rsp_ready,
    output txn_ready, req_cmd_in, req_data_in, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, rsp_cycles, rsp_stray
  );

  // The transaction source / calculator / result consumer side.
  modport slave (
    output txn_valid, txn_cmd, txn_param1, txn_param2, out_resp, out_data, rsp_ready,
    input  txn_ready, req_cmd_in, req_data_in, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, rsp_cycles, rsp_stray
  );
endinterface

// File: rtl/calc_port_sequencer.sv
// Drives one calc1_top request port with a two-cycle command/operand sequence and
// returns the first response (or a timeout) as a single result record.
module calc_port_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10
) (
  input logic                   c_clk,
  input logic                   reset,
  calc_port_sequencer_if.master port
);

  typedef enum logic [2:0] {StIdle, StCmd, StOp2, StWait, StDone} state_e;

  localparam logic [CntWidth-1:0] Timeout = CntWidth'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  calc_txn_t           txn_q, txn_d;
  calc_rsp_t           rsp_q, rsp_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                stray_q, stray_d;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= StIdle;
      txn_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;
    // Any response outside the window belongs to no transaction of ours.
    stray_d = stray_q | ((state_q != StWait) && (port.out_resp != 2'd0));

    unique case (state_q)
      StIdle: begin
        if (port.txn_valid) begin
          txn_d   = '{cmd: port.txn_cmd, param1: port.txn_param1, param2: port.txn_param2};
          state_d = StCmd;
        end
      end
      StCmd: state_d = StOp2;
      StOp2: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (port.out_resp != 2'd0) begin
          rsp_d   = '{resp: port.out_resp, data: port.out_data, timeout: 1'b0, cycles: cnt_inc};
          state_d = StDone;
        end else if (cnt_inc >= Timeout) begin
          rsp_d   = '{resp: 2'd0, data: '0, timeout: (txn_q.cmd != '0), cycles: Timeout};
          state_d = StDone;
        end
      end
      StDone: begin
        if (port.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Port drive is decoded from registered state only, so it changes on clock edges.
  always_comb begin
    port.req_cmd_in  = '0;
    port.req_data_in = '0;
    if (state_q == StCmd) begin
      port.req_cmd_in  = txn_q.cmd;
      port.req_data_in = txn_q.param1;
    end else if (state_q == StOp2) begin
      port.req_data_in = txn_q.param2;
    end
  end

  assign port.txn_ready   = (state_q == StIdle);
  assign port.rsp_valid   = (state_q == StDone);
  assign port.rsp_resp    = rsp_q.resp;
  assign port.rsp_data    = rsp_q.data;
  assign port.rsp_timeout = rsp_q.timeout;
  assign port.rsp_cycles  = rsp_q.cycles;
  assign port.rsp_stray   = stray_q;

endmodule

// File: tb/tb_calc_port_sequencer.sv
// Two sequencers (windows 10 and 4) share one stimulus stream; results are checked
// against a scoreboard filled when each transaction is driven.
module tb_calc_port_sequencer;
  import calc_pkg::*;

  localparam int unsigned WinA = 10;
  localparam int unsigned WinB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        txn_valid;
  logic [3:0]  txn_cmd;
  logic [31:0] txn_param1;
  logic [31:0] txn_param2;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        rsp_ready;

  always #5 clk = ~clk;

  calc_port_sequencer_if ia ();
  calc_port_sequencer_if ib ();

  assign ia.txn_valid  = txn_valid;
  assign ia.txn_cmd    = txn_cmd;
  assign ia.txn_param1 = txn_param1;
  assign ia.txn_param2 = txn_param2;
  assign ia.out_resp   = out_resp;
  assign ia.out_data   = out_data;
  assign ia.rsp_ready  = rsp_ready;
  assign ib.txn_valid  = txn_valid;
  assign ib.txn_cmd    = txn_cmd;
  assign ib.txn_param1 = txn_param1;
  assign ib.txn_param2 = txn_param2;
  assign ib.out_resp   = out_resp;
  assign ib.out_data   = out_data;
  assign ib.rsp_ready  = rsp_ready;

  calc_port_sequencer #(.TIMEOUT_CYCLES(WinA)) u_dut_a (.c_clk(clk), .reset(reset), .port(ia));
  calc_port_sequencer #(.TIMEOUT_CYCLES(WinB)) u_dut_b (.c_clk(clk), .reset(reset), .port(ib));

  int        errors = 0;
  int        checks = 0;
  calc_rsp_t exp_a_q[$];
  calc_rsp_t exp_b_q[$];
  logic      stray_a_exp = 1'b0;
  logic      stray_b_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic calc_rsp_t model(input logic [3:0] cmd, input int unsigned k,
                                      input logic [1:0] r, input logic [31:0] d,
                                      input int unsigned win);
    calc_rsp_t m;
    if (k != 0 && k <= win) m = '{resp: r, data: d, timeout: 1'b0, cycles: 8'(k)};
    else m = '{resp: 2'd0, data: 32'd0, timeout: (cmd != 4'd0), cycles: 8'(win)};
    return m;
  endfunction

  // k = 0 means the calculator never answers; otherwise it answers in cycle T+2+k.
  task automatic run_txn(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input int unsigned k, input logic [1:0] r,
                         input logic [31:0] d, input int unsigned stall);
    calc_rsp_t ea, eb;
    int        lat_a = 0;
    int        lat_b = 0;
    exp_a_q.push_back(model(cmd, k, r, d, WinA));
    exp_b_q.push_back(model(cmd, k, r, d, WinB));
    if (k > WinB && k != 0) stray_b_exp = 1'b1;
    @(negedge clk);
    txn_valid = 1'b1; txn_cmd = cmd; txn_param1 = a; txn_param2 = b;
    @(negedge clk);
    txn_valid = 1'b0;
    chk({tag, ".cmd_cycle.cmd"}, 32'(ia.req_cmd_in), 32'(cmd));
    chk({tag, ".cmd_cycle.data"}, ia.req_data_in, a);
    chk({tag, ".busy_ready"}, 32'(ia.txn_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".op2_cycle.cmd"}, 32'(ia.req_cmd_in), 32'd0);
    chk({tag, ".op2_cycle.data"}, ia.req_data_in, b);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, ".wait.data"}, ia.req_data_in, 32'd0);
      if (ia.rsp_valid && lat_a == 0) lat_a = n;
      if (ib.rsp_valid && lat_b == 0) lat_b = n;
      out_resp = (n == k) ? r : 2'd0;
      out_data = (n == k) ? d : 32'd0;
      if (lat_a != 0 && lat_b != 0) break;
    end
    out_resp = 2'd0; out_data = 32'd0;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    chk({tag, ".a.latency"}, 32'(lat_a), 32'(ea.cycles) + 32'd1);
    chk({tag, ".a.resp"}, 32'(ia.rsp_resp), 32'(ea.resp));
    chk({tag, ".a.data"}, ia.rsp_data, ea.data);
    chk({tag, ".a.timeout"}, 32'(ia.rsp_timeout), 32'(ea.timeout));
    chk({tag, ".a.cycles"}, 32'(ia.rsp_cycles), 32'(ea.cycles));
    chk({tag, ".b.latency"}, 32'(lat_b), 32'(eb.cycles) + 32'd1);
    chk({tag, ".b.resp"}, 32'(ib.rsp_resp), 32'(eb.resp));
    chk({tag, ".b.data"}, ib.rsp_data, eb.data);
    chk({tag, ".b.timeout"}, 32'(ib.rsp_timeout), 32'(eb.timeout));
    chk({tag, ".b.cycles"}, 32'(ib.rsp_cycles), 32'(eb.cycles));
    chk({tag, ".a.stray"}, 32'(ia.rsp_stray), 32'(stray_a_exp));
    chk({tag, ".b.stray"}, 32'(ib.rsp_stray), 32'(stray_b_exp));
    if (stall != 0) begin
      repeat (stall) @(negedge clk);
      chk({tag, ".stall.valid"}, 32'(ia.rsp_valid), 32'd1);
      chk({tag, ".stall.ready"}, 32'(ia.txn_ready), 32'd0);
      chk({tag, ".stall.cycles"}, 32'(ia.rsp_cycles), 32'(ea.cycles));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".after.a.valid"}, 32'(ia.rsp_valid), 32'd0);
    chk({tag, ".after.a.ready"}, 32'(ia.txn_ready), 32'd1);
    chk({tag, ".after.b.ready"}, 32'(ib.txn_ready), 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1; txn_valid = 1'b0; txn_cmd = '0; txn_param1 = '0; txn_param2 = '0;
    out_resp = '0; out_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(ia.txn_ready), 32'd1);
    chk("reset.valid", 32'(ia.rsp_valid), 32'd0);
    chk("reset.req_cmd", 32'(ia.req_cmd_in), 32'd0);
    chk("reset.req_data", ia.req_data_in, 32'd0);
    chk("reset.cycles", 32'(ia.rsp_cycles), 32'd0);
    chk("reset.stray", 32'(ia.rsp_stray), 32'd0);
    reset = 1'b0;

    run_txn("add", CmdAdd, 32'h5, 32'h1, 3, 2'd1, 32'h6, 0);
    run_txn("nop", CmdNop, 32'h64, 32'h27, 0, 2'd0, 32'd0, 0);
    run_txn("ovf", CmdAdd, 32'hFFFF_FFFF, 32'h1, 2, 2'd2, 32'h0, 3);
    run_txn("sub", CmdSub, 32'h22, 32'h23, 0, 2'd0, 32'd0, 0);
    run_txn("last", CmdShl, 32'h1, 32'h4, 10, 2'd1, 32'h10, 0);

    // Reset while the operand2 cycle is on the port.
    @(negedge clk);
    txn_valid = 1'b1; txn_cmd = CmdAdd; txn_param1 = 32'hAA; txn_param2 = 32'hBB;
    @(negedge clk);
    txn_valid = 1'b0;
    chk("rst_mid.cmd_cycle", 32'(ia.req_cmd_in), 32'(CmdAdd));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stray_a_exp = 1'b0; stray_b_exp = 1'b0;
    chk("rst_mid.req_cmd", 32'(ia.req_cmd_in), 32'd0);
    chk("rst_mid.req_data", ia.req_data_in, 32'd0);
    chk("rst_mid.ready", 32'(ia.txn_ready), 32'd1);
    chk("rst_mid.b.stray", 32'(ib.rsp_stray), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ia.rsp_valid || ib.rsp_valid) seen++;
    end
    chk("rst_mid.no_valid", 32'(seen), 32'd0);

    // Unsolicited response while idle.
    @(negedge clk);
    out_resp = 2'd1;
    @(negedge clk);
    out_resp = 2'd0;
    stray_a_exp = 1'b1; stray_b_exp = 1'b1;
    chk("stray.a", 32'(ia.rsp_stray), 32'd1);
    chk("stray.b", 32'(ib.rsp_stray), 32'd1);
    run_txn("good", CmdShr, 32'h80, 32'h1, 1, 2'd1, 32'h40, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("stray.cleared", 32'(ia.rsp_stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
